// File: rtl/calc_pkg.sv
// Shared calculator definitions: key codes, keypad scan states and the 4x4 key map.
// Used by keypad_scan and by the calculator input controller.
package calc_pkg;

    localparam logic [3:0] KEY_0   = 4'h0;
    localparam logic [3:0] KEY_1   = 4'h1;
    localparam logic [3:0] KEY_2   = 4'h2;
    localparam logic [3:0] KEY_3   = 4'h3;
    localparam logic [3:0] KEY_4   = 4'h4;
    localparam logic [3:0] KEY_5   = 4'h5;
    localparam logic [3:0] KEY_6   = 4'h6;
    localparam logic [3:0] KEY_7   = 4'h7;
    localparam logic [3:0] KEY_8   = 4'h8;
    localparam logic [3:0] KEY_9   = 4'h9;
    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_DIV = 4'hD;
    localparam logic [3:0] KEY_EQ  = 4'hE;
    localparam logic [3:0] KEY_CLR = 4'hF;

    typedef enum logic [1:0] {
        ST_SCAN         = 2'd0,
        ST_DEBOUNCE     = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_DONE = 2'd3
    } scan_state_t;

    // Physical key position (row, column) to calculator key code.
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = KEY_0;
        case ({row, col})
            4'b00_00: code = KEY_1;
            4'b00_01: code = KEY_2;
            4'b00_10: code = KEY_3;
            4'b00_11: code = KEY_ADD;
            4'b01_00: code = KEY_4;
            4'b01_01: code = KEY_5;
            4'b01_10: code = KEY_6;
            4'b01_11: code = KEY_SUB;
            4'b10_00: code = KEY_7;
            4'b10_01: code = KEY_8;
            4'b10_10: code = KEY_9;
            4'b10_11: code = KEY_MUL;
            4'b11_00: code = KEY_CLR;
            4'b11_01: code = KEY_0;
            4'b11_10: code = KEY_EQ;
            default:  code = KEY_DIV;
        endcase
        return code;
    endfunction

    // True when exactly one active-low column is asserted.
    function automatic logic cols_valid(input logic [3:0] cs);
        logic [3:0] low;
        low = ~cs;
        return (low != 4'h0) && ((low & (low - 4'h1)) == 4'h0);
    endfunction

    // Index of the asserted column (meaningful only when cols_valid).
    function automatic logic [1:0] col_index(input logic [3:0] cs);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!cs[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // One-hot active-low row drive pattern.
    function automatic logic [3:0] row_drive(input logic [1:0] row);
        logic [3:0] d;
        d      = 4'hF;
        d[row] = 1'b0;
        return d;
    endfunction

    // Equals and clear are one-shot keys; everything else may auto-repeat.
    function automatic logic key_repeats(input logic [3:0] code);
        return (code != KEY_EQ) && (code != KEY_CLR);
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Generic stable-count checker: counts consecutive cycles where sample equals
// reference while enabled; o_done_c marks the sample that reaches the threshold.
module keypad_debounce #(
    parameter int unsigned W     = 4,
    parameter int unsigned CNT_W = 6
) (
    input  logic             CLK_1K,
    input  logic             RSTN,
    input  logic             i_en,
    input  logic [W-1:0]     i_sample,
    input  logic [W-1:0]     i_ref,
    input  logic [CNT_W-1:0] i_thresh,
    output logic             o_done_c
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_match;

    assign w_match  = (i_sample == i_ref);
    assign o_done_c = i_en && w_match && (r_cnt >= (i_thresh - CNT_W'(1)));

    // Saturating run-length counter, cleared on mismatch or when disabled.
    always_ff @(posedge CLK_1K or negedge RSTN) begin
        if (!RSTN) begin
            r_cnt <= '0;
        end else if (!i_en || !w_match) begin
            r_cnt <= '0;
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with press/release debounce.
// Emits one flag strobe per accepted press with key_value valid in the same cycle.
// Optional auto-repeat while a key is held: define KEY_REPEAT_EN.
module keypad_scan
    import calc_pkg::*;
#(
    parameter int unsigned SCAN_DWELL    = 4,
    parameter int unsigned DEBOUNCE      = 20,
    parameter int unsigned REPEAT_DELAY  = 500,
    parameter int unsigned REPEAT_PERIOD = 150
) (
    input  logic       CLK_1K,
    input  logic       RSTN,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key_value,
    output logic       flag,
    output logic       key_held
);

    localparam int unsigned MAX_A = (SCAN_DWELL > DEBOUNCE) ? SCAN_DWELL : DEBOUNCE;
    localparam int unsigned MAX_B = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DWELL - 1);
    localparam logic [CNT_W-1:0] DB_THRESH  = CNT_W'(DEBOUNCE);
`ifdef KEY_REPEAT_EN
    // Reload leaves exactly REPEAT_PERIOD cycles to the next strobe (needs PERIOD <= DELAY).
    localparam logic [CNT_W-1:0] REP_LAST   = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] REP_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);
`endif

    logic [3:0]       r_col_s1;
    logic [3:0]       r_col_s2;
    scan_state_t      r_state;
    logic [1:0]       r_row;
    logic [3:0]       r_row_n;
    logic [CNT_W-1:0] r_dwell;
    logic [3:0]       r_pat;
    logic [3:0]       r_key_value;
    logic             r_flag;
    logic             r_key_held;
    logic             r_armed;
    logic             r_dirty;
`ifdef KEY_REPEAT_EN
    logic [CNT_W-1:0] r_rep;
`endif

    logic [3:0] w_cs;
    logic       w_cs_valid;
    logic       w_cs_idle;
    logic       w_press_en;
    logic       w_press_done;
    logic       w_rel_en;
    logic       w_rel_done;

    assign w_cs       = r_col_s2;
    assign w_cs_valid = cols_valid(w_cs);
    assign w_cs_idle  = (w_cs == 4'hF);
    assign w_press_en = (r_state == ST_DEBOUNCE);
    assign w_rel_en   = (r_state == ST_HELD);

    assign row_n     = r_row_n;
    assign key_value = r_key_value;
    assign flag      = r_flag;
    assign key_held  = r_key_held;

    // Two-flop synchronizer for the asynchronous column inputs (idle = pulled high).
    always_ff @(posedge CLK_1K or negedge RSTN) begin
        if (!RSTN) begin
            r_col_s1 <= 4'hF;
            r_col_s2 <= 4'hF;
        end else begin
            r_col_s1 <= col_n;
            r_col_s2 <= r_col_s1;
        end
    end

    keypad_debounce #(.W(4), .CNT_W(CNT_W)) u_press (
        .CLK_1K   (CLK_1K),
        .RSTN     (RSTN),
        .i_en     (w_press_en),
        .i_sample (w_cs),
        .i_ref    (r_pat),
        .i_thresh (DB_THRESH),
        .o_done_c (w_press_done)
    );

    keypad_debounce #(.W(4), .CNT_W(CNT_W)) u_release (
        .CLK_1K   (CLK_1K),
        .RSTN     (RSTN),
        .i_en     (w_rel_en),
        .i_sample (w_cs),
        .i_ref    (4'hF),
        .i_thresh (DB_THRESH),
        .o_done_c (w_rel_done)
    );

    // Scan / debounce / held / release FSM. After a release the scanner is disarmed
    // until one full sweep sees no key, so a key left down from before is never accepted.
    always_ff @(posedge CLK_1K or negedge RSTN) begin
        if (!RSTN) begin
            r_state     <= ST_SCAN;
            r_row       <= 2'd0;
            r_row_n     <= 4'b1110;
            r_dwell     <= '0;
            r_pat       <= 4'hF;
            r_key_value <= 4'h0;
            r_flag      <= 1'b0;
            r_key_held  <= 1'b0;
            r_armed     <= 1'b1;
            r_dirty     <= 1'b0;
`ifdef KEY_REPEAT_EN
            r_rep       <= '0;
`endif
        end else begin
            r_flag <= 1'b0;
            case (r_state)
                ST_SCAN: begin
                    if (r_dwell == DWELL_LAST) begin
                        r_dwell <= '0;
                        if (w_cs_valid && r_armed) begin
                            r_pat   <= w_cs;
                            r_state <= ST_DEBOUNCE;
                        end else begin
                            r_row   <= r_row + 2'd1;
                            r_row_n <= row_drive(r_row + 2'd1);
                            if (r_row == 2'd3) begin
                                r_armed <= r_armed | (!r_dirty && w_cs_idle);
                                r_dirty <= 1'b0;
                            end else begin
                                r_dirty <= r_dirty | !w_cs_idle;
                            end
                        end
                    end else begin
                        r_dwell <= r_dwell + CNT_W'(1);
                    end
                end
                ST_DEBOUNCE: begin
                    if (w_cs != r_pat) begin
                        r_state <= ST_SCAN;
                        r_row   <= r_row + 2'd1;
                        r_row_n <= row_drive(r_row + 2'd1);
                        r_dwell <= '0;
                    end else if (w_press_done) begin
                        r_key_value <= key_map(r_row, col_index(r_pat));
                        r_flag      <= 1'b1;
                        r_key_held  <= 1'b1;
                        r_state     <= ST_HELD;
`ifdef KEY_REPEAT_EN
                        r_rep       <= '0;
`endif
                    end
                end
                ST_HELD: begin
                    if (w_rel_done) begin
                        r_key_held <= 1'b0;
                        r_state    <= ST_RELEASE_DONE;
                    end
`ifdef KEY_REPEAT_EN
                    else if (!w_cs_idle && key_repeats(r_key_value)) begin
                        if (r_rep == REP_LAST) begin
                            r_flag <= 1'b1;
                            r_rep  <= REP_RELOAD;
                        end else begin
                            r_rep <= r_rep + CNT_W'(1);
                        end
                    end
`endif
                end
                ST_RELEASE_DONE: begin
                    r_state <= ST_SCAN;
                    r_row   <= 2'd0;
                    r_row_n <= 4'b1110;
                    r_dwell <= '0;
                    r_armed <= 1'b0;
                    r_dirty <= 1'b0;
                end
                default: begin
                    r_state <= ST_SCAN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: behavioural keypad model plus per-scenario tasks.
module tb_keypad_scan;

    localparam int DWELL = 4;
    localparam int DB    = 20;
    localparam int RD    = 500;
    localparam int RP    = 150;

    logic        CLK_1K = 1'b0;
    logic        RSTN   = 1'b0;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [3:0]  key_value;
    logic        flag;
    logic        key_held;
    logic [15:0] key_mask = 16'h0000;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int dbl_cnt  = 0;
    logic prev_flag = 1'b0;
    int         flag_cyc[$];
    logic [3:0] flag_val[$];

    // Reference key table, index = row*4 + col.
    logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hF, 4'h0, 4'hE, 4'hD};

    keypad_scan #(
        .SCAN_DWELL    (DWELL),
        .DEBOUNCE      (DB),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .CLK_1K    (CLK_1K),
        .RSTN      (RSTN),
        .col_n     (col_n),
        .row_n     (row_n),
        .key_value (key_value),
        .flag      (flag),
        .key_held  (key_held)
    );

    always #5 CLK_1K = ~CLK_1K;

    always @(posedge CLK_1K) cyc <= cyc + 1;

    // Physical keypad: a pressed key pulls its column low when its row is driven low.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (key_mask[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
    end

    // Flag recorder on the falling edge.
    always @(negedge CLK_1K) begin
        if (flag === 1'b1) begin
            flag_cyc.push_back(cyc);
            flag_val.push_back(key_value);
            if (prev_flag) dbl_cnt++;
        end
        prev_flag = (flag === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK_1K);
        #2;
    endtask

    task automatic press(input int idx);
        key_mask = 16'h0001 << idx;
    endtask

    task automatic test_reset;
        logic [3:0] exp_row;
        RSTN = 1'b0;
        key_mask = 16'h0000;
        tick(3);
        checks++; if (row_n !== 4'b1110) begin failures++; $display("FAIL reset_row_n got=%b exp=1110", row_n); end
        checks++; if (key_value !== 4'h0) begin failures++; $display("FAIL reset_key_value got=%h exp=0", key_value); end
        checks++; if (flag !== 1'b0) begin failures++; $display("FAIL reset_flag got=%b exp=0", flag); end
        checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL reset_key_held got=%b exp=0", key_held); end
        RSTN = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick(1);
            exp_row = 4'hF;
            exp_row[(k / DWELL) % 4] = 1'b0;
            checks++;
            if (row_n !== exp_row) begin
                failures++; $display("FAIL scan_row_n k=%0d got=%b exp=%b", k, row_n, exp_row);
            end
        end
        tick(200);
        checks++; if (flag_cyc.size() != 0) begin failures++; $display("FAIL idle_flags got=%0d exp=0", flag_cyc.size()); end
    endtask

    task automatic test_single_press;
        int base, p, waited;
        base = flag_cyc.size();
        press(1*4+2);
        p = cyc;
        tick(100);
        checks++; if (flag_cyc.size() - base != 1) begin failures++; $display("FAIL press6_count got=%0d exp=1", flag_cyc.size() - base); end
        if (flag_cyc.size() > base) begin
            checks++; if (flag_val[base] !== 4'h6) begin failures++; $display("FAIL press6_flag_value got=%h exp=6", flag_val[base]); end
            checks++;
            if (flag_cyc[base] < p + DB || flag_cyc[base] > p + DB + 4*DWELL + 4) begin
                failures++; $display("FAIL press6_latency got=%0d exp=%0d..%0d", flag_cyc[base] - p, DB, DB + 4*DWELL + 4);
            end
        end
        checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL press6_held got=%b exp=1", key_held); end
        checks++; if (key_value !== 4'h6) begin failures++; $display("FAIL press6_key_value got=%h exp=6", key_value); end
        key_mask = 16'h0000;
        waited = 0;
        while (key_held === 1'b1 && waited < 100) begin tick(1); waited++; end
        checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL release6_held got=%b exp=0", key_held); end
        checks++; if (waited < DB) begin failures++; $display("FAIL release6_debounce got=%0d exp>=%0d", waited, DB); end
        tick(100);
        checks++; if (flag_cyc.size() - base != 1) begin failures++; $display("FAIL release6_count got=%0d exp=1", flag_cyc.size() - base); end
        checks++; if (key_value !== 4'h6) begin failures++; $display("FAIL release6_value_hold got=%h exp=6", key_value); end
    endtask

    task automatic test_bounce;
        int base, s;
        base = flag_cyc.size();
        for (int i = 0; i < 4; i++) begin
            press(3*4+2); tick(5);
            key_mask = 16'h0000; tick(5);
        end
        checks++; if (flag_cyc.size() - base != 0) begin failures++; $display("FAIL bounce_early got=%0d exp=0", flag_cyc.size() - base); end
        press(3*4+2);
        s = cyc;
        tick(100);
        checks++; if (flag_cyc.size() - base != 1) begin failures++; $display("FAIL bounce_count got=%0d exp=1", flag_cyc.size() - base); end
        if (flag_cyc.size() > base) begin
            checks++; if (flag_val[base] !== 4'hE) begin failures++; $display("FAIL bounce_value got=%h exp=E", flag_val[base]); end
            checks++; if (flag_cyc[base] < s + DB) begin failures++; $display("FAIL bounce_timing got=%0d exp>=%0d", flag_cyc[base] - s, DB); end
        end
        key_mask = 16'h0000;
        tick(150);
    endtask

    task automatic test_second_key;
        int base;
        base = flag_cyc.size();
        press(0*4+2);
        tick(80);
        checks++; if (flag_cyc.size() - base != 1 || key_value !== 4'h3) begin
            failures++; $display("FAIL key3_accept got=%0d/%h exp=1/3", flag_cyc.size() - base, key_value); end
        key_mask = key_mask | (16'h0001 << (2*4+1));
        tick(100);
        checks++; if (flag_cyc.size() - base != 1) begin failures++; $display("FAIL key8_while_held got=%0d exp=1", flag_cyc.size() - base); end
        press(2*4+1);
        tick(300);
        checks++; if (flag_cyc.size() - base != 1) begin failures++; $display("FAIL key8_swapped got=%0d exp=1", flag_cyc.size() - base); end
        checks++; if (key_value !== 4'h3) begin failures++; $display("FAIL key8_swapped_value got=%h exp=3", key_value); end
        checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL key3_released_held got=%b exp=0", key_held); end
        key_mask = 16'h0000;
        tick(100);
        base = flag_cyc.size();
        press(2*4+1);
        tick(80);
        checks++; if (flag_cyc.size() - base != 1) begin failures++; $display("FAIL key8_fresh_count got=%0d exp=1", flag_cyc.size() - base); end
        checks++; if (key_value !== 4'h8) begin failures++; $display("FAIL key8_fresh_value got=%h exp=8", key_value); end
        key_mask = 16'h0000;
        tick(150);
    endtask

    task automatic test_reset_midpress;
        int base;
        base = flag_cyc.size();
        press(1*4+1);
        tick(80);
        checks++; if (flag_cyc.size() - base != 1 || key_value !== 4'h5) begin
            failures++; $display("FAIL key5_accept got=%0d/%h exp=1/5", flag_cyc.size() - base, key_value); end
        RSTN = 1'b0;
        tick(3);
        checks++; if (row_n !== 4'b1110) begin failures++; $display("FAIL midrst_row_n got=%b exp=1110", row_n); end
        checks++; if (key_value !== 4'h0) begin failures++; $display("FAIL midrst_key_value got=%h exp=0", key_value); end
        checks++; if (flag !== 1'b0) begin failures++; $display("FAIL midrst_flag got=%b exp=0", flag); end
        checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL midrst_key_held got=%b exp=0", key_held); end
        base = flag_cyc.size();
        RSTN = 1'b1;
        tick(80);
        checks++; if (flag_cyc.size() - base != 1) begin failures++; $display("FAIL postrst_count got=%0d exp=1", flag_cyc.size() - base); end
        checks++; if (key_value !== 4'h5) begin failures++; $display("FAIL postrst_value got=%h exp=5", key_value); end
        checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL postrst_held got=%b exp=1", key_held); end
        key_mask = 16'h0000;
        tick(150);
    endtask

    task automatic test_repeat;
        int base, n;
        int gaps[4];
        gaps = '{RD, RP, RP, RP};
        base = flag_cyc.size();
        press(0*4+3);
        tick(1020);
        n = flag_cyc.size() - base;
`ifdef KEY_REPEAT_EN
        checks++; if (n != 5) begin failures++; $display("FAIL repeatA_count got=%0d exp=5", n); end
        if (n == 5) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (flag_cyc[base+i+1] - flag_cyc[base+i] != gaps[i]) begin
                    failures++; $display("FAIL repeatA_gap%0d got=%0d exp=%0d", i, flag_cyc[base+i+1] - flag_cyc[base+i], gaps[i]);
                end
            end
        end
`else
        checks++; if (n != 1) begin failures++; $display("FAIL holdA_count got=%0d exp=1 (gap0=%0d)", n, gaps[0]); end
`endif
        for (int i = base; i < flag_cyc.size(); i++) begin
            checks++; if (flag_val[i] !== 4'hA) begin failures++; $display("FAIL holdA_value got=%h exp=A", flag_val[i]); end
        end
        key_mask = 16'h0000;
        tick(150);
        base = flag_cyc.size();
        press(3*4+2);
        tick(1020);
        checks++; if (flag_cyc.size() - base != 1) begin failures++; $display("FAIL holdE_count got=%0d exp=1", flag_cyc.size() - base); end
        checks++; if (key_value !== 4'hE) begin failures++; $display("FAIL holdE_value got=%h exp=E", key_value); end
        key_mask = 16'h0000;
        tick(150);
    endtask

    task automatic test_invalid;
        int base;
        base = flag_cyc.size();
        key_mask = 16'h0003;
        tick(150);
        checks++; if (flag_cyc.size() - base != 0) begin failures++; $display("FAIL invalid_two_cols got=%0d exp=0", flag_cyc.size() - base); end
        key_mask = 16'h0000;
        tick(100);
    endtask

    task automatic test_random;
        int base, k, hold, gap;
        for (int t = 0; t < 12; t++) begin
            k    = int'($urandom_range(0, 15));
            hold = int'($urandom_range(60, 200));
            gap  = int'($urandom_range(100, 200));
            base = flag_cyc.size();
            press(k);
            tick(hold);
            checks++; if (flag_cyc.size() - base != 1) begin failures++; $display("FAIL rand%0d_count key=%0d got=%0d exp=1", t, k, flag_cyc.size() - base); end
            checks++; if (key_value !== kmap[k]) begin failures++; $display("FAIL rand%0d_value key=%0d got=%h exp=%h", t, k, key_value, kmap[k]); end
            checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL rand%0d_held got=%b exp=1", t, key_held); end
            key_mask = 16'h0000;
            tick(gap);
            checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL rand%0d_release got=%b exp=0", t, key_held); end
        end
    endtask

    task automatic test_no_double;
        checks++; if (dbl_cnt != 0) begin failures++; $display("FAIL back_to_back_flags got=%0d exp=0", dbl_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_second_key();
        test_reset_midpress();
        test_repeat();
        test_invalid();
        test_random();
        test_no_double();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
